// File: rtl/command_sequencer.sv
// Command sequencer: picks a pseudo-random command each round, times the response window,
// pulses enable at the window close and advances or ends the game from the checker's state.
//
// state  | meaning
// IDLE   | game stopped; window length and round count held at their start values
// ARM    | waiting for the checker to report 000 before opening the first window
// WINDOW | response window running; enable marks its last cycle
// LOST   | game over; command and round frozen until start drops
module command_sequencer #(
    parameter int unsigned WIN_INIT = 50_000_000,
    parameter int unsigned WIN_MIN  = 12_500_000,
    parameter int unsigned WIN_STEP = 2_500_000,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int unsigned ROUND_W  = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [2:0]         game_state,
    output logic [1:0]         command,
    output logic               enable,
    output logic [ROUND_W-1:0] round,
    output logic               playing,
    output logic               lost
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARM    = 2'd1;
    localparam logic [1:0] WINDOW = 2'd2;
    localparam logic [1:0] LOST   = 2'd3;

    localparam logic [2:0] GS_CHECK = 3'b000;
    localparam logic [2:0] GS_QUIT  = 3'b001;
    localparam logic [2:0] GS_RIGHT = 3'b011;

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [31:0] timer;
    logic [31:0] win_len;
    logic [31:0] win_next;
    logic [1:0]  pick;
    logic        lfsr_fb;
    logic        round_max;

    always_comb begin
        pick      = (lfsr[1:0] == 2'b10) ? {lfsr[2], 1'b1} : lfsr[1:0];
        lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        // win_len never drops below WIN_MIN, so this difference cannot underflow
        win_next  = ((win_len - WIN_MIN) >= WIN_STEP) ? (win_len - WIN_STEP) : WIN_MIN;
        round_max = &round;
    end

    assign enable  = (state == WINDOW) && (timer == 32'd0);
    assign playing = (state == ARM) || (state == WINDOW);
    assign lost    = (state == LOST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            command <= 2'b00;
            round   <= '0;
            lfsr    <= SEED;
            timer   <= 32'd0;
            win_len <= WIN_INIT;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (!start) begin
                state   <= IDLE;
                round   <= '0;
                win_len <= WIN_INIT;
                timer   <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        round   <= '0;
                        win_len <= WIN_INIT;
                        state   <= ARM;
                    end
                    ARM: begin
                        if (game_state == GS_CHECK) begin
                            state   <= WINDOW;
                            command <= pick;
                            timer   <= win_len - 32'd1;
                        end
                    end
                    WINDOW: begin
                        if (timer == 32'd0) begin
                            if (game_state == GS_RIGHT) begin
                                if (!round_max) begin
                                    round <= round + 1'b1;
                                end
                                win_len <= win_next;
                                command <= pick;
                                timer   <= win_next - 32'd1;
                            end else begin
                                state <= LOST;
                            end
                        end else if (game_state == GS_QUIT) begin
                            state <= LOST;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end
                    LOST: begin
                        state <= LOST;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_command_sequencer.sv
// Bench for command_sequencer: directed vector table, window-length sequence and randomized play,
// all checked against a game-level reference model; a second instance checks round saturation.
module tb_command_sequencer;
    localparam int unsigned WI   = 10;
    localparam int unsigned WM   = 4;
    localparam int unsigned WS   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] game_state;
    logic [1:0] command, command2;
    logic       enable, enable2;
    logic [7:0] round;
    logic [1:0] round2;
    logic       playing, playing2;
    logic       lost, lost2;

    always #5 clk = ~clk;

    command_sequencer #(.WIN_INIT(WI), .WIN_MIN(WM), .WIN_STEP(WS), .SEED(SEED), .ROUND_W(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .game_state(game_state),
        .command(command), .enable(enable), .round(round), .playing(playing), .lost(lost)
    );

    command_sequencer #(.WIN_INIT(WI), .WIN_MIN(WM), .WIN_STEP(WS), .SEED(SEED), .ROUND_W(2)) dut2 (
        .clk(clk), .resetn(resetn), .start(start), .game_state(game_state),
        .command(command2), .enable(enable2), .round(round2), .playing(playing2), .lost(lost2)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Reference model: game phase, cycles left in the window, window length, rounds won.
    typedef enum {P_IDLE, P_ARM, P_WIN, P_LOST} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_left  = 0;
    longint      m_len   = WI;
    int          m_round = 0;
    int          m_cmd   = 0;
    logic [15:0] m_lfsr  = SEED;

    function automatic int pick_of(input logic [15:0] l);
        int p;
        p = int'(l) % 4;
        if (p == 2) p = l[2] ? 3 : 1;
        return p;
    endfunction

    task automatic model_step();
        int p;
        if (!resetn) begin
            m_phase = P_IDLE; m_cmd = 0; m_round = 0; m_lfsr = SEED; m_left = 0; m_len = WI;
            return;
        end
        p = pick_of(m_lfsr);
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        if (!start) begin
            m_phase = P_IDLE; m_round = 0; m_len = WI;
            return;
        end
        case (m_phase)
            P_IDLE: m_phase = P_ARM;
            P_ARM: if (game_state == 3'b000) begin
                m_phase = P_WIN; m_cmd = p; m_left = int'(m_len);
            end
            P_WIN: begin
                if (m_left == 1) begin
                    if (game_state == 3'b011) begin
                        m_round++;
                        m_len = (m_len - WS < WM) ? longint'(WM) : m_len - WS;
                        m_cmd = p; m_left = int'(m_len);
                    end else m_phase = P_LOST;
                end else if (game_state == 3'b001) m_phase = P_LOST;
                else m_left--;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("m_enable",  {31'b0, enable},  (m_phase == P_WIN && m_left == 1) ? 1 : 0);
        check("m_playing", {31'b0, playing}, (m_phase == P_ARM || m_phase == P_WIN) ? 1 : 0);
        check("m_lost",    {31'b0, lost},    (m_phase == P_LOST) ? 1 : 0);
        check("m_round",   {24'b0, round},   (m_round > 255) ? 255 : m_round);
        check("m_round_w2", {30'b0, round2}, (m_round > 3) ? 3 : m_round);
        check("m_command", {30'b0, command}, m_cmd);
    endtask

    typedef struct {
        bit       rstn;
        bit       st;
        bit [2:0] gs;
        int       n;
        bit       en;
        bit       play;
        bit       lst;
        int       rnd;
        int       cmd;   // -1: not checked
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rstn, input bit st, input bit [2:0] gs, input int n,
                       input bit en, input bit play, input bit lst, input int rnd, input int cmd);
        vec_t v;
        v.rstn = rstn; v.st = st; v.gs = gs; v.n = n;
        v.en = en; v.play = play; v.lst = lst; v.rnd = rnd; v.cmd = cmd;
        tbl.push_back(v);
    endtask

    initial begin
        int wcyc;
        int r;
        resetn = 1'b0; start = 1'b0; game_state = 3'b000;

        //  rstn st gs  n  en pl lo rnd cmd
        add(0, 0, 0, 2, 0, 0, 0, 0, 0);
        add(1, 1, 2, 1, 0, 1, 0, 0, -1);
        add(1, 1, 2, 3, 0, 1, 0, 0, -1);
        add(1, 1, 0, 1, 0, 1, 0, 0, -1);
        add(1, 1, 0, 8, 0, 1, 0, 0, -1);
        add(1, 1, 3, 1, 1, 1, 0, 0, -1);
        add(1, 1, 3, 1, 0, 1, 0, 1, -1);
        add(1, 1, 0, 6, 1, 1, 0, 1, -1);
        add(1, 1, 3, 1, 0, 1, 0, 2, -1);
        add(1, 1, 0, 3, 1, 1, 0, 2, -1);
        add(1, 1, 3, 1, 0, 1, 0, 3, -1);
        add(1, 1, 0, 3, 1, 1, 0, 3, -1);
        add(1, 1, 0, 1, 0, 0, 1, 3, -1);
        add(1, 1, 3, 4, 0, 0, 1, 3, -1);
        add(1, 0, 3, 1, 0, 0, 0, 0, -1);
        add(1, 1, 2, 1, 0, 1, 0, 0, -1);
        add(1, 1, 0, 1, 0, 1, 0, 0, -1);
        add(1, 1, 0, 9, 1, 1, 0, 0, -1);
        add(1, 1, 1, 1, 0, 0, 1, 0, -1);
        add(1, 0, 1, 1, 0, 0, 0, 0, -1);
        add(1, 1, 0, 2, 0, 1, 0, 0, -1);
        add(1, 1, 2, 3, 0, 1, 0, 0, -1);
        add(1, 1, 1, 1, 0, 0, 1, 0, -1);
        add(1, 1, 0, 12, 0, 0, 1, 0, -1);
        add(1, 0, 0, 1, 0, 0, 0, 0, -1);
        add(1, 1, 0, 2, 0, 1, 0, 0, -1);
        add(1, 1, 0, 9, 1, 1, 0, 0, -1);
        add(1, 1, 3, 1, 0, 1, 0, 1, -1);
        add(1, 1, 0, 2, 0, 1, 0, 1, -1);
        add(1, 0, 0, 1, 0, 0, 0, 0, -1);
        add(1, 1, 0, 2, 0, 1, 0, 0, -1);
        add(1, 1, 0, 9, 1, 1, 0, 0, -1);
        add(1, 1, 3, 1, 0, 1, 0, 1, -1);
        add(1, 1, 0, 3, 0, 1, 0, 1, -1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 2, 0, 1, 0, 0, -1);
        add(1, 1, 0, 9, 1, 1, 0, 0, -1);
        add(1, 1, 3, 1, 0, 1, 0, 1, -1);
        add(1, 1, 0, 6, 1, 1, 0, 1, -1);
        add(1, 1, 3, 1, 0, 1, 0, 2, -1);
        add(1, 1, 0, 3, 1, 1, 0, 2, -1);
        add(1, 1, 3, 1, 0, 1, 0, 3, -1);
        add(1, 1, 0, 3, 1, 1, 0, 3, -1);
        add(1, 1, 3, 1, 0, 1, 0, 4, -1);
        add(1, 1, 0, 3, 1, 1, 0, 4, -1);
        add(1, 1, 3, 1, 0, 1, 0, 5, -1);

        foreach (tbl[i]) begin
            resetn = tbl[i].rstn; start = tbl[i].st; game_state = tbl[i].gs;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d_enable", i),  {31'b0, enable},  {31'b0, tbl[i].en});
            check($sformatf("vec%0d_playing", i), {31'b0, playing}, {31'b0, tbl[i].play});
            check($sformatf("vec%0d_lost", i),    {31'b0, lost},    {31'b0, tbl[i].lst});
            check($sformatf("vec%0d_round", i),   {24'b0, round},   tbl[i].rnd);
            check($sformatf("vec%0d_round_w2", i), {30'b0, round2}, (tbl[i].rnd > 3) ? 3 : tbl[i].rnd);
            if (tbl[i].cmd >= 0) check($sformatf("vec%0d_command", i), {30'b0, command}, tbl[i].cmd);
        end

        // First window after a fresh start lasts WIN_INIT cycles, enable on the last one.
        resetn = 1'b0; start = 1'b0; game_state = 3'b000;
        tick();
        resetn = 1'b1; start = 1'b1;
        tick();
        tick();
        wcyc = 1;
        while (!enable && wcyc < 50) begin
            tick();
            wcyc++;
        end
        check("first_window_len", wcyc, WI);
        game_state = 3'b011;
        tick();
        wcyc = 1;
        game_state = 3'b000;
        while (!enable && wcyc < 50) begin
            tick();
            wcyc++;
        end
        check("second_window_len", wcyc, WI - WS);

        // Randomized play: mostly right answers, occasional quits, stops and resets.
        for (int c = 0; c < 4000; c++) begin
            resetn = ($urandom_range(0, 199) != 0);
            start  = ($urandom_range(0, 49) != 0);
            r = $urandom_range(0, 99);
            if (r < 3)       game_state = 3'b001;
            else if (r < 50) game_state = 3'b011;
            else if (r < 85) game_state = 3'b000;
            else begin
                case ($urandom_range(0, 3))
                    0: game_state = 3'b010;
                    1: game_state = 3'b101;
                    2: game_state = 3'b111;
                    default: game_state = 3'b100;
                endcase
            end
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
